// File: rtl/rd_pkg.sv
// rtl/rd_pkg.sv - shared command layout and field widths for the bank read issuer
`ifndef ADDR_LENTH
`define ADDR_LENTH 16
`endif

package rd_pkg;

    localparam int RD_LEN_W  = 4;
    localparam int RD_SRC_W  = 4;
    localparam int RD_ADDR_W = `ADDR_LENTH;

    // Routed read command, same bit order as the crossbar payload
    typedef struct packed {
        logic                 eop;
        logic [RD_LEN_W-1:0]  len;
        logic [RD_SRC_W-1:0]  src;
        logic [RD_ADDR_W-1:0] addr;
    } rd_cmd_t;

endpackage

// File: rtl/rd_rsp_fifo.sv
// rtl/rd_rsp_fifo.sv - response FIFO with registered head and occupancy count
module rd_rsp_fifo
    import rd_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               din,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic             out_vld_q, out_vld_d;
    logic [W-1:0]     out_q, out_d;
    logic             pop, out_free, mem_wr, mem_rd;

    assign pop      = out_vld_q & out_rdy;
    assign out_free = ~out_vld_q | pop;
    assign out_vld  = out_vld_q;
    assign dout     = out_q;
    assign count    = mcnt_q + CNT_W'(out_vld_q);

    // Head register refills from storage first, else bypasses the incoming word
    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        out_vld_d = out_vld_q;
        out_d     = out_q;
        mem_wr    = 1'b0;
        mem_rd    = 1'b0;
        if (out_free) begin
            if (mcnt_q != '0) begin
                out_d     = mem_q[rptr_q];
                out_vld_d = 1'b1;
                mem_rd    = 1'b1;
                mem_wr    = push;
            end else if (push) begin
                out_d     = din;
                out_vld_d = 1'b1;
            end else begin
                out_vld_d = 1'b0;
            end
        end else begin
            mem_wr = push;
        end
        if (mem_rd) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        if (mem_wr) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + PTR_W'(1);
        end
        mcnt_d = mcnt_q + CNT_W'(mem_wr) - CNT_W'(mem_rd);
    end

    // Pointer, count and head state; reset flushes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mcnt_q    <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mcnt_q    <= mcnt_d;
            out_vld_q <= out_vld_d;
            out_q     <= out_d;
        end
    end

    // Storage array carries data only, so it needs no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Credit upstream must make a push into a full FIFO impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && (count == CNT_W'(DEPTH)) && !pop));

endmodule

// File: rtl/dcp_rd_bank_issue.sv
// rtl/dcp_rd_bank_issue.sv - per-bank read burst issuer, optional RD_ISSUE_STAT_EN counters
`ifndef ADDR_LENTH
`define ADDR_LENTH 16
`endif

module dcp_rd_bank_issue
    import rd_pkg::*;
#(
    parameter int ADDR_W    = `ADDR_LENTH,
    parameter int DW        = 512,
    parameter int RD_LAT    = 2,
    parameter int RSP_DEPTH = 8
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iCmdVld,
    output logic                oCmdRdy,
    input  logic [ADDR_W+8:0]   iCmdPld,
    input  logic [3:0]          iCmdDst,
    output logic                oMemRdEn,
    output logic [ADDR_W-1:0]   oMemAddr,
    input  logic [DW-1:0]       iMemRdData,
    output logic                oRspVld,
    input  logic                iRspRdy,
    output logic [DW-1:0]       oRspData,
    output logic [RD_SRC_W-1:0] oRspSrc,
    output logic                oRspLast
`ifdef RD_ISSUE_STAT_EN
    ,
    output logic [31:0]         oStatCmd,
    output logic [31:0]         oStatBeat,
    output logic [31:0]         oStatStall
`endif
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int FW    = DW + RD_SRC_W + 1;

    logic [0:0]                     state_q, state_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [RD_SRC_W-1:0]            src_q, src_d;
    logic [RD_LEN_W-1:0]            cnt_q, cnt_d;
    logic                           eop_q, eop_d;
    logic [CNT_W-1:0]               inflight_q, inflight_d;
    logic [RD_LAT-1:0]              tag_vld_q, tag_vld_d;
    logic [RD_LAT-1:0]              tag_last_q, tag_last_d;
    logic [RD_LAT-1:0][RD_SRC_W-1:0] tag_src_q, tag_src_d;

    logic [CNT_W-1:0] fifo_count;
    logic             credit, issue, pipe_out_vld;
    logic [FW-1:0]    fifo_din, fifo_dout;
    logic             unused_ok;

    // Residual route bits carry no meaning at this point in the path
    assign unused_ok = ^iCmdDst;

    assign credit       = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(RSP_DEPTH);
    assign issue        = (state_q == S_BURST) && credit;
    assign pipe_out_vld = tag_vld_q[RD_LAT-1];

    assign oCmdRdy  = (state_q == S_IDLE);
    assign oMemRdEn = issue;
    assign oMemAddr = addr_q;

    // Command capture, burst expansion and in-flight accounting
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        eop_d      = eop_q;
        inflight_d = inflight_q;
        case (state_q)
            S_IDLE: begin
                if (iCmdVld) begin
                    addr_d  = iCmdPld[ADDR_W-1:0];
                    src_d   = iCmdPld[ADDR_W+3:ADDR_W];
                    cnt_d   = iCmdPld[ADDR_W+7:ADDR_W+4];
                    eop_d   = iCmdPld[ADDR_W+8];
                    state_d = S_BURST;
                end
            end
            default: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - RD_LEN_W'(1);
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end
                end
            end
        endcase
        if (issue && !pipe_out_vld) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue && pipe_out_vld) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    // Tag shift register tracks the fixed SRAM latency alongside each read
    always_comb begin
        tag_vld_d     = tag_vld_q;
        tag_src_d     = tag_src_q;
        tag_last_d    = tag_last_q;
        tag_vld_d[0]  = issue;
        tag_src_d[0]  = src_q;
        tag_last_d[0] = eop_q && (cnt_q == '0);
        for (int i = 1; i < RD_LAT; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_src_d[i]  = tag_src_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
        end
    end

    // State registers; clearing the tag valids discards SRAM data still in flight
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            src_q      <= '0;
            cnt_q      <= '0;
            eop_q      <= 1'b0;
            inflight_q <= '0;
            tag_vld_q  <= '0;
            tag_src_q  <= '0;
            tag_last_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            eop_q      <= eop_d;
            inflight_q <= inflight_d;
            tag_vld_q  <= tag_vld_d;
            tag_src_q  <= tag_src_d;
            tag_last_q <= tag_last_d;
        end
    end

    assign fifo_din = {tag_last_q[RD_LAT-1], tag_src_q[RD_LAT-1], iMemRdData};

    rd_rsp_fifo #(
        .W     (FW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (iClk),
        .rst     (iRst),
        .push    (pipe_out_vld),
        .din     (fifo_din),
        .out_vld (oRspVld),
        .out_rdy (iRspRdy),
        .dout    (fifo_dout),
        .count   (fifo_count)
    );

    assign oRspData = fifo_dout[DW-1:0];
    assign oRspSrc  = fifo_dout[DW+RD_SRC_W-1:DW];
    assign oRspLast = fifo_dout[FW-1];

`ifdef RD_ISSUE_STAT_EN
    logic [31:0] stat_cmd_q, stat_cmd_d;
    logic [31:0] stat_beat_q, stat_beat_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Saturating event counters: accepts, issues, credit-blocked burst cycles
    always_comb begin
        stat_cmd_d   = stat_cmd_q;
        stat_beat_d  = stat_beat_q;
        stat_stall_d = stat_stall_q;
        if (oCmdRdy && iCmdVld && stat_cmd_q != '1) begin
            stat_cmd_d = stat_cmd_q + 32'd1;
        end
        if (issue && stat_beat_q != '1) begin
            stat_beat_d = stat_beat_q + 32'd1;
        end
        if ((state_q == S_BURST) && !credit && stat_stall_q != '1) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    // Counter registers, cleared only by reset
    always_ff @(posedge iClk) begin
        if (iRst) begin
            stat_cmd_q   <= '0;
            stat_beat_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_cmd_q   <= stat_cmd_d;
            stat_beat_q  <= stat_beat_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign oStatCmd   = stat_cmd_q;
    assign oStatBeat  = stat_beat_q;
    assign oStatStall = stat_stall_q;
`endif

endmodule

// File: tb/tb_dcp_rd_bank_issue.sv
// tb/tb_dcp_rd_bank_issue.sv - self-checking bench for dcp_rd_bank_issue
`timescale 1ns/1ps

module tb_dcp_rd_bank_issue;
    import rd_pkg::*;

    localparam int ADDR_W    = 16;
    localparam int DW        = 512;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 8;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
    } iss_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic [3:0]    src;
        logic          last;
    } rsp_t;

    logic              clk = 1'b0;
    logic              iRst = 1'b1;
    logic              iCmdVld = 1'b0;
    logic              oCmdRdy;
    logic [ADDR_W+8:0] iCmdPld = '0;
    logic [3:0]        iCmdDst = '0;
    logic              oMemRdEn;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DW-1:0]     iMemRdData;
    logic              oRspVld;
    logic              iRspRdy = 1'b1;
    logic [DW-1:0]     oRspData;
    logic [3:0]        oRspSrc;
    logic              oRspLast;
`ifdef RD_ISSUE_STAT_EN
    logic [31:0]       oStatCmd, oStatBeat, oStatStall;
`endif

    int   vecs = 0;
    int   errs = 0;
    int   cyc  = 0;
    iss_t iss_q[$];
    rsp_t rsp_q[$];
    rsp_t exp_q[$];
    logic [ADDR_W-1:0] sa [RD_LAT];

    dcp_rd_bank_issue #(
        .ADDR_W    (ADDR_W),
        .DW        (DW),
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .iClk       (clk),
        .iRst       (iRst),
        .iCmdVld    (iCmdVld),
        .oCmdRdy    (oCmdRdy),
        .iCmdPld    (iCmdPld),
        .iCmdDst    (iCmdDst),
        .oMemRdEn   (oMemRdEn),
        .oMemAddr   (oMemAddr),
        .iMemRdData (iMemRdData),
        .oRspVld    (oRspVld),
        .iRspRdy    (iRspRdy),
        .oRspData   (oRspData),
        .oRspSrc    (oRspSrc),
        .oRspLast   (oRspLast)
`ifdef RD_ISSUE_STAT_EN
        ,
        .oStatCmd   (oStatCmd),
        .oStatBeat  (oStatBeat),
        .oStatStall (oStatStall)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] word_of(input logic [ADDR_W-1:0] a);
        return {16{a, ~a}};
    endfunction

    // SRAM model: word for an address appears RD_LAT cycles after the read
    always @(posedge clk) begin
        sa[0] <= oMemAddr;
        for (int i = 1; i < RD_LAT; i++) sa[i] <= sa[i-1];
    end
    assign iMemRdData = word_of(sa[RD_LAT-1]);

    // Passive recorder of issues and delivered responses
    always @(negedge clk) begin
        if (oMemRdEn) iss_q.push_back('{cyc, oMemAddr});
        if (oRspVld && iRspRdy) rsp_q.push_back('{cyc, oRspData, oRspSrc, oRspLast});
    end

    task automatic model_cmd(input logic [ADDR_W-1:0] a, input logic [3:0] s,
                             input logic [3:0] l, input logic e);
        for (int i = 0; i <= int'(l); i++) begin
            logic [ADDR_W-1:0] ai;
            ai = a + ADDR_W'(i);
            exp_q.push_back('{0, word_of(ai), s, e && (i == int'(l))});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept cycle
    task automatic send_cmd(input logic [ADDR_W-1:0] a, input logic [3:0] s,
                            input logic [3:0] l, input logic e,
                            output int acc, output bit ok);
        ok  = 1'b0;
        acc = -1;
        iCmdPld = {e, l, s, a};
        iCmdDst = 4'($urandom);
        iCmdVld = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (oCmdRdy) begin
                ok  = 1'b1;
                acc = cyc;
                break;
            end
        end
        @(posedge clk); #1;
        iCmdVld = 1'b0;
        if (ok) model_cmd(a, s, l, e);
    endtask

    task automatic wait_rsp(input int n, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (rsp_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_all();
        iss_q.delete();
        rsp_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        iRst = 1'b1; iCmdVld = 1'b0; iRspRdy = 1'b1;
        repeat (3) @(posedge clk);
        #1 iRst = 1'b0;
        @(negedge clk);
        vecs++; if (oCmdRdy !== 1'b1) begin errs++; $display("FAIL reset_cmd_rdy got %b want 1", oCmdRdy); end
        vecs++; if (oMemRdEn !== 1'b0) begin errs++; $display("FAIL reset_rd_en got %b want 0", oMemRdEn); end
        vecs++; if (oMemAddr !== '0) begin errs++; $display("FAIL reset_addr got %h want 0", oMemAddr); end
        vecs++; if (oRspVld !== 1'b0) begin errs++; $display("FAIL reset_rsp_vld got %b want 0", oRspVld); end
        vecs++; if (oRspData !== '0) begin errs++; $display("FAIL reset_rsp_data got %h want 0", oRspData); end
        vecs++; if (oRspSrc !== 4'd0) begin errs++; $display("FAIL reset_rsp_src got %h want 0", oRspSrc); end
        vecs++; if (oRspLast !== 1'b0) begin errs++; $display("FAIL reset_rsp_last got %b want 0", oRspLast); end
        @(posedge clk); #1;
        clear_all();
    endtask

    task automatic test_basic();
        int t; bit ok;
        clear_all();
        iRspRdy = 1'b1;
        send_cmd(16'h0010, 4'd5, 4'd3, 1'b1, t, ok);
        wait_rsp(4, ok);
        vecs++; if (!ok || iss_q.size() != 4) begin errs++; $display("FAIL basic_count got iss=%0d rsp=%0d want 4/4", iss_q.size(), rsp_q.size()); end
        for (int i = 0; i < 4 && i < iss_q.size() && i < rsp_q.size(); i++) begin
            vecs++; if (iss_q[i].addr !== 16'h0010 + 16'(i) || iss_q[i].cyc != t + 1 + i) begin
                errs++; $display("FAIL basic_issue[%0d] got %h@%0d want %h@%0d", i, iss_q[i].addr, iss_q[i].cyc, 16'h0010 + 16'(i), t + 1 + i);
            end
            vecs++; if (rsp_q[i].cyc != t + 2 + RD_LAT + i || rsp_q[i].src !== 4'd5 || rsp_q[i].last !== (i == 3) || rsp_q[i].data !== exp_q[i].data) begin
                errs++; $display("FAIL basic_rsp[%0d] got cyc=%0d src=%h last=%b want cyc=%0d src=5 last=%b", i, rsp_q[i].cyc, rsp_q[i].src, rsp_q[i].last, t + 2 + RD_LAT + i, i == 3);
            end
        end
    endtask

    task automatic test_wrap();
        int t; bit ok;
        logic [3:0] s;
        clear_all();
        s = 4'($urandom);
        send_cmd(16'hFFFF, s, 4'd1, 1'b1, t, ok);
        wait_rsp(2, ok);
        vecs++; if (!ok || iss_q.size() != 2) begin errs++; $display("FAIL wrap_count got %0d want 2", iss_q.size()); end
        if (iss_q.size() == 2) begin
            vecs++; if (iss_q[0].addr !== 16'hFFFF) begin errs++; $display("FAIL wrap_addr0 got %h want ffff", iss_q[0].addr); end
            vecs++; if (iss_q[1].addr !== 16'h0000) begin errs++; $display("FAIL wrap_addr1 got %h want 0000", iss_q[1].addr); end
        end
        for (int i = 0; i < rsp_q.size() && i < exp_q.size(); i++) begin
            vecs++; if (rsp_q[i].data !== exp_q[i].data || rsp_q[i].src !== exp_q[i].src || rsp_q[i].last !== exp_q[i].last) begin
                errs++; $display("FAIL wrap_rsp[%0d] got src=%h last=%b want src=%h last=%b", i, rsp_q[i].src, rsp_q[i].last, exp_q[i].src, exp_q[i].last);
            end
        end
    endtask

    task automatic test_backpressure();
        int t, r; bit ok;
        logic [ADDR_W-1:0] a;
        logic [3:0] s;
        iRst = 1'b1;
        @(posedge clk); #1 iRst = 1'b0;
        clear_all();
        a = 16'($urandom);
        s = 4'($urandom);
        iRspRdy = 1'b0;
        send_cmd(a, s, 4'd15, 1'b1, t, ok);
        repeat (30) begin @(posedge clk); #1; end
        vecs++; if (iss_q.size() != RSP_DEPTH) begin errs++; $display("FAIL bp_issue_cap got %0d want %0d", iss_q.size(), RSP_DEPTH); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vecs++; if (oMemRdEn !== 1'b0) begin errs++; $display("FAIL bp_stalled got %b want 0", oMemRdEn); end
            vecs++; if (oRspVld !== 1'b1 || oRspData !== exp_q[0].data || oRspSrc !== s || oRspLast !== 1'b0) begin
                errs++; $display("FAIL bp_hold got vld=%b src=%h last=%b want vld=1 src=%h last=0", oRspVld, oRspSrc, oRspLast, s);
            end
        end
        @(posedge clk); #1;
        iRspRdy = 1'b1;
        r = cyc;
        wait_rsp(16, ok);
        vecs++; if (!ok || iss_q.size() != 16 || rsp_q.size() != 16) begin errs++; $display("FAIL bp_total got iss=%0d rsp=%0d want 16/16", iss_q.size(), rsp_q.size()); end
        if (iss_q.size() == 16) begin
            vecs++; if (iss_q[8].cyc != r + 1 || iss_q[15].cyc != r + 8) begin
                errs++; $display("FAIL bp_resume got %0d..%0d want %0d..%0d", iss_q[8].cyc, iss_q[15].cyc, r + 1, r + 8);
            end
        end
        for (int i = 0; i < rsp_q.size() && i < exp_q.size(); i++) begin
            vecs++; if (rsp_q[i].data !== exp_q[i].data || rsp_q[i].src !== exp_q[i].src || rsp_q[i].last !== exp_q[i].last) begin
                errs++; $display("FAIL bp_rsp[%0d] got src=%h last=%b want src=%h last=%b", i, rsp_q[i].src, rsp_q[i].last, exp_q[i].src, exp_q[i].last);
            end
        end
`ifdef RD_ISSUE_STAT_EN
        vecs++; if (oStatCmd !== 32'd1) begin errs++; $display("FAIL stat_cmd got %0d want 1", oStatCmd); end
        vecs++; if (oStatBeat !== 32'd16) begin errs++; $display("FAIL stat_beat got %0d want 16", oStatBeat); end
        vecs++; if (oStatStall !== 32'(r - t - 8)) begin errs++; $display("FAIL stat_stall got %0d want %0d", oStatStall, r - t - 8); end
`endif
    endtask

    task automatic test_back_to_back();
        int t1, t2; bit ok1, ok2, ok;
        clear_all();
        iRspRdy = 1'b1;
        send_cmd(16'($urandom), 4'd1, 4'd0, 1'b0, t1, ok1);
        send_cmd(16'($urandom), 4'd2, 4'd0, 1'b1, t2, ok2);
        vecs++; if (!ok1 || !ok2 || t2 - t1 != 2) begin errs++; $display("FAIL b2b_gap got %0d want 2", t2 - t1); end
        wait_rsp(2, ok);
        vecs++; if (rsp_q.size() != 2) begin errs++; $display("FAIL b2b_count got %0d want 2", rsp_q.size()); end
        for (int i = 0; i < rsp_q.size() && i < exp_q.size(); i++) begin
            vecs++; if (rsp_q[i].src !== 4'(i + 1) || rsp_q[i].last !== (i == 1) || rsp_q[i].data !== exp_q[i].data) begin
                errs++; $display("FAIL b2b_rsp[%0d] got src=%h last=%b want src=%0d last=%b", i, rsp_q[i].src, rsp_q[i].last, i + 1, i == 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t; bit ok;
        clear_all();
        iRspRdy = 1'b1;
        send_cmd(16'h0200, 4'd9, 4'd5, 1'b1, t, ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (iss_q.size() >= 3) begin ok = 1'b1; break; end
        end
        vecs++; if (!ok) begin errs++; $display("FAIL rst_mid_reach got %0d issues want 3", iss_q.size()); end
        iRst = 1'b1;
        @(posedge clk); #1;
        iRst = 1'b0;
        clear_all();
        @(negedge clk);
        vecs++; if (oCmdRdy !== 1'b1 || oMemRdEn !== 1'b0 || oMemAddr !== '0) begin
            errs++; $display("FAIL rst_mid_ctrl got rdy=%b en=%b addr=%h want 1/0/0", oCmdRdy, oMemRdEn, oMemAddr);
        end
        vecs++; if (oRspVld !== 1'b0 || oRspData !== '0 || oRspSrc !== 4'd0 || oRspLast !== 1'b0) begin
            errs++; $display("FAIL rst_mid_rsp got vld=%b src=%h last=%b want 0/0/0", oRspVld, oRspSrc, oRspLast);
        end
        repeat (20) begin @(posedge clk); #1; end
        vecs++; if (rsp_q.size() != 0 || iss_q.size() != 0) begin
            errs++; $display("FAIL rst_mid_stale got rsp=%0d iss=%0d want 0/0", rsp_q.size(), iss_q.size());
        end
        send_cmd(16'h0300, 4'd3, 4'd2, 1'b1, t, ok);
        wait_rsp(3, ok);
        vecs++; if (rsp_q.size() != 3) begin errs++; $display("FAIL rst_mid_after got %0d want 3", rsp_q.size()); end
        for (int i = 0; i < rsp_q.size() && i < exp_q.size(); i++) begin
            vecs++; if (rsp_q[i].data !== exp_q[i].data || rsp_q[i].src !== exp_q[i].src || rsp_q[i].last !== exp_q[i].last) begin
                errs++; $display("FAIL rst_mid_rsp[%0d] got src=%h last=%b want src=%h last=%b", i, rsp_q[i].src, rsp_q[i].last, exp_q[i].src, exp_q[i].last);
            end
        end
    endtask

    task automatic test_random();
        int sent;
        bit acc, done;
        logic [ADDR_W-1:0] a;
        logic [3:0] s, l;
        logic e;
        clear_all();
        sent = 0;
        done = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (sent == 8 && rsp_q.size() >= exp_q.size()) begin done = 1'b1; break; end
            iRspRdy = ($urandom_range(0, 3) != 0);
            if (!iCmdVld && sent < 8 && $urandom_range(0, 1) == 1) begin
                a = 16'($urandom); s = 4'($urandom); l = 4'($urandom); e = 1'($urandom);
                iCmdPld = {e, l, s, a};
                iCmdVld = 1'b1;
            end
            @(negedge clk);
            acc = iCmdVld && oCmdRdy;
            @(posedge clk); #1;
            if (acc) begin
                model_cmd(a, s, l, e);
                sent++;
                iCmdVld = 1'b0;
            end
        end
        iCmdVld = 1'b0;
        iRspRdy = 1'b1;
        vecs++; if (!done || rsp_q.size() != exp_q.size()) begin
            errs++; $display("FAIL rand_count got %0d want %0d (sent %0d)", rsp_q.size(), exp_q.size(), sent);
        end
        for (int i = 0; i < rsp_q.size() && i < exp_q.size(); i++) begin
            vecs++; if (rsp_q[i].data !== exp_q[i].data || rsp_q[i].src !== exp_q[i].src || rsp_q[i].last !== exp_q[i].last) begin
                errs++; $display("FAIL rand_rsp[%0d] got src=%h last=%b want src=%h last=%b", i, rsp_q[i].src, rsp_q[i].last, exp_q[i].src, exp_q[i].last);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
